// File: rtl/fu_div_iter.sv
// Multi-cycle radix-2 restoring integer divider (DIV/DIVU/REM/REMU).
// Handshakes through EN/busy/valid. Flush aborts the operation; res keeps the last completed result.
module fu_div_iter #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic             is_rem, b_zero, ovf, neg_q, neg_r;
  logic [WIDTH-1:0] a_raw, rem, dq, dvs, res_q;
  logic [CW-1:0]    cnt;

  logic             in_signed, in_a_neg, in_b_neg, in_b_zero, in_ovf;
  logic             accept, early;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub, q_fix, r_fix, res_nxt;
  logic             ge;

  assign in_signed = ~op[0];
  assign in_a_neg  = in_signed & A[WIDTH-1];
  assign in_b_neg  = in_signed & B[WIDTH-1];
  assign in_b_zero = (B == '0);
  assign in_ovf    = in_signed && (A == MIN_VAL) && (B == '1);
  assign accept    = EN && !flush && (state == IDLE || state == DONE);
  assign early     = EARLY_OUT && (in_b_zero || in_ovf);

  // Trial subtract: when rem_sh >= dvs the true difference fits in WIDTH bits.
  assign rem_sh = {rem, dq[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, dvs});
  assign sub    = rem_sh[WIDTH-1:0] - dvs;

  always_comb begin
    q_fix = neg_q ? -dq : dq;
    r_fix = neg_r ? -rem : rem;
    // Special cases override whatever the iteration produced, so both EARLY_OUT modes agree.
    if (b_zero) begin
      q_fix = '1;
      r_fix = a_raw;
    end else if (ovf) begin
      q_fix = MIN_VAL;
      r_fix = '0;
    end
    res_nxt = is_rem ? r_fix : q_fix;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = early ? FIX : CALC;
        else        state_nxt = IDLE;
      end
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_rem <= 1'b0;
      b_zero <= 1'b0;
      ovf    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_raw  <= '0;
      rem    <= '0;
      dq     <= '0;
      dvs    <= '0;
      cnt    <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        is_rem <= op[1];
        b_zero <= in_b_zero;
        ovf    <= in_ovf;
        neg_q  <= in_a_neg ^ in_b_neg;
        neg_r  <= in_a_neg;
        a_raw  <= A;
        dq     <= in_a_neg ? -A : A;
        dvs    <= in_b_neg ? -B : B;
        rem    <= '0;
        cnt    <= CW'(WIDTH);
      end else if (state == CALC) begin
        rem <= ge ? sub : rem_sh[WIDTH-1:0];
        dq  <= {dq[WIDTH-2:0], ge};
        cnt <= cnt - CW'(1);
      end
      if (state == FIX && !flush) res_q <= res_nxt;
    end
  end

  assign busy  = (state == CALC) || (state == FIX);
  assign valid = (state == DONE) && !flush;
  assign res   = res_q;

endmodule

// File: doc/fu_div_iter.md
Name: fu_div_iter

Overview:
- Parametrised multi-cycle integer divide functional unit for the out-of-order core's execute stage.
- Successor to the single-opcode, IP-based divide FU; it needs no vendor divider core.
- Supports signed and unsigned quotient and remainder (RISC-V DIV/DIVU/REM/REMU semantics) with radix-2 restoring iteration.
- Handshakes with the issue/scoreboard logic via EN/busy/valid and supports flush on mispredict.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- EARLY_OUT, 1, when 1 divide-by-zero and signed-overflow cases complete in 2 cycles; when 0 they take the full WIDTH+2 latency.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- EN  input  1  start request; sampled only when busy=0
- flush  input  1  abort any in-flight operation (synchronous)
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- A  input  WIDTH  dividend
- B  input  WIDTH  divisor
- busy  output  1  operation in flight; EN ignored while high
- valid  output  1  one-cycle pulse; res is valid this cycle
- res  output  WIDTH  quotient or remainder per op; held until the next completion

Behaviour:
- Reset: rst=1 at a clock edge puts the FSM in IDLE. busy=0, valid=0, res=0, all internal registers cleared. Reset wins over EN and flush in the same cycle.
- FSM states and transitions:
  - IDLE → CALC: on EN=1 and busy=0. Latch op, A and B. Record signs. Load the absolute-value dividend/divisor (signed ops) or raw values (unsigned). Clear the partial remainder. Count ← WIDTH.
  - IDLE → FIX (when EARLY_OUT=1): on EN=1 with either B==0, or signed op with A==MIN (1 followed by WIDTH-1 zeros) and B==all-ones. Skips CALC.
  - CALC: one quotient bit per cycle. Shift {rem, dq} left by 1. Trial-subtract the divisor from rem (WIDTH+1-bit subtraction). If non-negative, keep the difference and set the quotient LSB to 1. Decrement count. After WIDTH iterations → FIX.
  - FIX: select and sign-correct the result. Quotient negated if signs differ (signed ops). Remainder takes the dividend's sign. Load res; next state DONE.
  - DONE: valid=1 for exactly this cycle; busy=0. If EN=1 in DONE, accept the new operation (back-to-back, → CALC or FIX); otherwise → IDLE.
- Special results:
  - Divide by zero: quotient = all-ones; remainder = A.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - With EARLY_OUT=0 both cases still iterate and must produce the same values.
- Latency, with EN sampled at edge t0:
  - Normal case: valid=1 in the cycle following edge t0+WIDTH+1.
  - Early-out case: valid=1 in the cycle following edge t0+1.
- busy: high from the cycle after acceptance through the FIX cycle inclusive; low in IDLE and DONE.
- EN while busy=1: ignored. Latched operands are unaffected and no second result is produced.
- flush=1 (no rst): FSM → IDLE next cycle, busy=0, valid=0.
  - If flush coincides with DONE, valid for that cycle is suppressed.
  - res keeps its last completed value.
  - EN in the same cycle as flush is ignored.
- Operands and op are sampled only at acceptance; they may change freely afterwards.
- Sign handling: absolute value of MIN is MIN interpreted as unsigned, so the iteration uses WIDTH-bit unsigned magnitudes.

Test Plan:
- WIDTH=32, DIVU A=100 B=7 → res=14 (0x0000000E), valid exactly 34 cycles after EN; REMU same operands → res=2.
- DIV A=0xFFFFFFF9 (−7) B=2 → res=0xFFFFFFFD (−3); REM same operands → res=0xFFFFFFFF (−1); REM A=7 B=0xFFFFFFFE (−2) → res=1.
- DIVU A=5 B=0 → res=0xFFFFFFFF, valid 2 cycles after EN (EARLY_OUT=1); REM A=5 B=0 → res=5; repeat with EARLY_OUT=0 → same values at 34 cycles.
- DIV A=0x80000000 B=0xFFFFFFFF → res=0x80000000; REM same operands → 0.
- Start DIVU 100/7, pulse EN with DIVU 9/3 at cycle 5 → ignored, only res=14 reported. Issue EN with DIVU 9/3 in the DONE cycle → res=3 exactly 34 cycles later.
- Start DIVU, assert flush at cycle 10 → no valid pulse, busy=0 next cycle, res unchanged. Separately, assert rst at cycle 10 → busy=0, valid=0, res=0, and a new operation completes correctly afterwards.
